// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus Tx_WR/Tx_BUSY handshake sequencer feeding a UART transmitter.
// Define TX_FEEDER_OVF_EN to add the sticky overflow flag (ovf, ovf_clr).
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              tx_enable,
    output logic              Tx_WR,
    output logic [7:0]        Tx_DATA,
    input  logic              Tx_BUSY,
    output logic              idle
`ifdef TX_FEEDER_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign pop   = (state == LOAD);
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            Tx_DATA <= '0;
        else if (pop)
            Tx_DATA <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        Tx_WR      = 1'b0;
        unique case (state)
            IDLE: if (!empty && tx_enable && !Tx_BUSY) state_next = LOAD;
            LOAD: state_next = REQ;
            REQ: begin
                Tx_WR = 1'b1;
                if (Tx_BUSY)
                    state_next = WAIT;
            end
            WAIT: if (!Tx_BUSY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign idle = (state == IDLE) && empty;

`ifdef TX_FEEDER_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf <= 1'b0;
        else if (wr_en && full && !pop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule
